// File: rtl/xor_arbiter.sv
// Two-requester round-robin arbiter sharing one registered WIDTH-bit XOR datapath.
// One-deep result slot with back-to-back refill and a consumed-result counter.
module xor_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_op1,
  input  logic [WIDTH-1:0] a_op2,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_op1,
  input  logic [WIDTH-1:0] b_op2,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic {IDLE, FULL} state_t;

  state_t           state;
  logic             last_b;
  logic             can_accept;
  logic             accept;
  logic             res_xfer;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;

  // Grants depend only on valids, slot state, res_ready and the pointer, never on operands.
  always_comb begin
    can_accept = rst_n && ((state == IDLE) || res_ready);
    a_ready    = can_accept && a_valid && (!b_valid || last_b);
    b_ready    = can_accept && b_valid && (!a_valid || !last_b);
    accept     = a_ready || b_ready;
    res_xfer   = res_valid && res_ready;
    op1        = b_ready ? b_op1 : a_op1;
    op2        = b_ready ? b_op2 : a_op2;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
      op_count  <= '0;
      last_b    <= 1'b1;
    end else begin
      if (res_xfer)
        op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= FULL;
            res_valid <= 1'b1;
          end
        end
        FULL: begin
          if (res_xfer && !accept) begin
            state     <= IDLE;
            res_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          res_valid <= 1'b0;
        end
      endcase
      if (accept) begin
        res_data <= op1 ^ op2;
        res_id   <= b_ready;
        last_b   <= b_ready;
      end
    end
  end

endmodule
